// File: rtl/redmule_tcdm_scheduler.sv
// Shares one TCDM port among the X/W/Y load streams and the Z store stream, and routes in-order load responses back.
// Defining REDMULE_SCHED_STATS_EN adds per-requester grant counters and a stall counter.
module redmule_tcdm_scheduler #(
   parameter int NREQ            = 4,
   parameter int BURST_LEN       = 8,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    clear_i,
   input  logic                    enable_i,
   input  logic [NREQ-1:0]         req_i,
   input  logic [NREQ-1:0]         wen_i,
   output logic [NREQ-1:0]         gnt_o,
   output logic [NREQ-1:0]         rvalid_o,
   output logic [$clog2(NREQ)-1:0] sel_o,
   output logic                    tcdm_req_o,
   output logic                    tcdm_wen_o,
   input  logic                    tcdm_gnt_i,
   input  logic                    tcdm_r_valid_i,
   output logic                    busy_o,
   output logic                    err_o,
`ifdef REDMULE_SCHED_STATS_EN
   output logic [NREQ*32-1:0]      grant_cnt_o,
   output logic [31:0]             stall_cnt_o,
`endif
   output logic                    dbg_state_o
);

   localparam int SEL_W  = $clog2(NREQ);
   localparam int PTR_W  = $clog2(MAX_OUTSTANDING);
   localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
   localparam int BCNT_W = $clog2(BURST_LEN + 1);
   localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(NREQ - 1);

   typedef enum logic {IDLE, LOCKED} state_e;

   state_e             state_q, state_d;
   logic [SEL_W-1:0]   owner_q, owner_d, last_owner_q, last_owner_d;
   logic [BCNT_W-1:0]  burst_cnt_q, burst_cnt_d;
   logic [SEL_W-1:0]   fifo_mem_q [MAX_OUTSTANDING];
   logic [SEL_W-1:0]   fifo_mem_d [MAX_OUTSTANDING];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
   logic               err_q, err_d;

   logic [SEL_W-1:0]   winner, cand, sel;
   logic               load_block, hs, push, pop;

   // Round-robin: the candidate closest after last_owner wins, so scan from farthest to nearest.
   always_comb begin
      winner = last_owner_q;
      cand   = last_owner_q;
      for (int k = NREQ; k >= 1; k--) begin
         cand = SEL_W'((int'(last_owner_q) + k) % NREQ);
         if (req_i[cand]) winner = cand;
      end
   end

   // TCDM handshake: a transfer happens in the cycle where tcdm_req_o and tcdm_gnt_i are both high;
   // the granted requester sees gnt_o in that same cycle and must hold req_i until then.
   always_comb begin
      sel        = (state_q == LOCKED) ? owner_q : winner;
      load_block = wen_i[sel] & (fifo_cnt_q == CNT_W'(MAX_OUTSTANDING));
      tcdm_req_o = req_i[sel] & enable_i & ~load_block;
      tcdm_wen_o = tcdm_req_o ? wen_i[sel] : 1'b1;
      hs         = tcdm_req_o & tcdm_gnt_i;
      push       = hs & tcdm_wen_o;
      pop        = tcdm_r_valid_i & (fifo_cnt_q != '0);
      gnt_o      = '0;
      rvalid_o   = '0;
      if (hs)  gnt_o[sel] = 1'b1;
      if (pop) rvalid_o[fifo_mem_q[rd_ptr_q]] = 1'b1;
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      burst_cnt_d  = burst_cnt_q;
      if (enable_i) begin
         case (state_q)
            IDLE: begin
               if (hs) begin
                  last_owner_d = sel;
                  if (BURST_LEN > 1) begin
                     state_d     = LOCKED;
                     owner_d     = sel;
                     burst_cnt_d = BCNT_W'(1);
                  end
               end
            end
            LOCKED: begin
               if (!req_i[owner_q]) begin
                  state_d     = IDLE;
                  burst_cnt_d = '0;
               end else if (hs) begin
                  if (burst_cnt_q == BCNT_W'(BURST_LEN - 1)) begin
                     state_d     = IDLE;
                     burst_cnt_d = '0;
                  end else begin
                     burst_cnt_d = burst_cnt_q + BCNT_W'(1);
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
      if (clear_i) begin
         state_d      = IDLE;
         owner_d      = '0;
         last_owner_d = LAST_RST;
         burst_cnt_d  = '0;
      end
   end

   // Responses are popped even while disabled; an unmatched response only raises err.
   always_comb begin
      fifo_mem_d = fifo_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q;
      err_d      = err_q;
      if (push) begin
         fifo_mem_d[wr_ptr_q] = sel;
         wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop) fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      if (!push && pop) fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      if (tcdm_r_valid_i && (fifo_cnt_q == '0)) err_d = 1'b1;
      if (clear_i) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         fifo_cnt_d = '0;
         err_d      = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         owner_q      <= '0;
         last_owner_q <= LAST_RST;
         burst_cnt_q  <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         fifo_cnt_q   <= '0;
         err_q        <= 1'b0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_mem_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         burst_cnt_q  <= burst_cnt_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         fifo_cnt_q   <= fifo_cnt_d;
         err_q        <= err_d;
         fifo_mem_q   <= fifo_mem_d;
      end
   end

   assign sel_o       = sel;
   assign busy_o      = (state_q == LOCKED) | (fifo_cnt_q != '0);
   assign err_o       = err_q;
   assign dbg_state_o = (state_q == LOCKED);

`ifdef REDMULE_SCHED_STATS_EN
   logic [31:0] grant_cnt_q [NREQ];
   logic [31:0] grant_cnt_d [NREQ];
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      grant_cnt_d = grant_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (enable_i) begin
         if (hs) grant_cnt_d[sel] = grant_cnt_q[sel] + 32'd1;
         if (req_i[sel] && !tcdm_req_o) stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (clear_i) begin
         for (int i = 0; i < NREQ; i++) grant_cnt_d[i] = '0;
         stall_cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NREQ; i++) grant_cnt_q[i] <= '0;
         stall_cnt_q <= '0;
      end else begin
         grant_cnt_q <= grant_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   always_comb begin
      grant_cnt_o = '0;
      for (int i = 0; i < NREQ; i++) grant_cnt_o[i*32 +: 32] = grant_cnt_q[i];
   end
   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_redmule_tcdm_scheduler.sv
// Bench for redmule_tcdm_scheduler: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a queue-based model of the scheduler.
module tb_redmule_tcdm_scheduler;

   localparam int NREQ      = 4;
   localparam int BURST_LEN = 8;
   localparam int MAX_OUT   = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       clear = 1'b0, enable = 1'b1;
   logic [3:0] req = 4'b0000, wen = 4'b0111;
   logic       gnt_in = 1'b0, r_valid = 1'b0;
   logic [3:0] gnt_o, rvalid_o;
   logic [1:0] sel_o;
   logic       tcdm_req, tcdm_wen, busy, err, dbg_state;

   redmule_tcdm_scheduler #(.NREQ(NREQ), .BURST_LEN(BURST_LEN), .MAX_OUTSTANDING(MAX_OUT)) dut (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .enable_i(enable),
      .req_i(req), .wen_i(wen), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .sel_o(sel_o),
      .tcdm_req_o(tcdm_req), .tcdm_wen_o(tcdm_wen), .tcdm_gnt_i(gnt_in),
      .tcdm_r_valid_i(r_valid), .busy_o(busy), .err_o(err), .dbg_state_o(dbg_state)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // ---------------- scoreboard / model ----------------
   logic [1:0] exp_q[$];     // requester IDs of loads awaiting a response
   bit         m_locked = 1'b0;
   int         m_owner = 0;
   int         m_last = NREQ - 1;
   int         m_burst = 0;
   bit         m_err = 1'b0;
   logic [3:0] exp_gnt_last = 4'b0;

   int  resp_due[$];          // cycles at which the TCDM returns load responses
   int  resp_lat = 1;
   int  last_due = 0;
   bit  auto_rsp = 1'b1;

   int         e_sel;
   bit         e_found;
   logic       e_req, e_wen, e_hs;
   logic [3:0] e_gnt, e_rv;

   function automatic void model_reset();
      m_locked = 1'b0;
      m_owner  = 0;
      m_last   = NREQ - 1;
      m_burst  = 0;
      m_err    = 1'b0;
      exp_q.delete();
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (m_locked) e_sel = m_owner;
         else begin
            e_sel   = m_last;
            e_found = 1'b0;
            for (int k = 1; k <= NREQ; k++) begin
               if (!e_found && req[(m_last + k) % NREQ]) begin
                  e_sel   = (m_last + k) % NREQ;
                  e_found = 1'b1;
               end
            end
         end
         e_req = req[e_sel] && enable && !(wen[e_sel] && (exp_q.size() == MAX_OUT));
         e_wen = e_req ? wen[e_sel] : 1'b1;
         e_hs  = e_req && gnt_in;
         e_gnt = e_hs ? (4'b0001 << e_sel) : 4'b0000;
         e_rv  = (r_valid && exp_q.size() > 0) ? (4'b0001 << exp_q[0]) : 4'b0000;

         check("sel_o", 32'(sel_o), 32'(e_sel));
         check("tcdm_req_o", 32'(tcdm_req), 32'(e_req));
         check("tcdm_wen_o", 32'(tcdm_wen), 32'(e_wen));
         check("gnt_o", 32'(gnt_o), 32'(e_gnt));
         check("rvalid_o", 32'(rvalid_o), 32'(e_rv));
         check("busy_o", 32'(busy), 32'(m_locked || exp_q.size() > 0));
         check("err_o", 32'(err), 32'(m_err));

         exp_gnt_last = e_gnt;
         if (e_hs && e_wen) begin
            last_due = (cyc + resp_lat > last_due + 1) ? cyc + resp_lat : last_due + 1;
            resp_due.push_back(last_due);
         end

         if (clear) model_reset();
         else begin
            if (r_valid) begin
               if (exp_q.size() > 0) void'(exp_q.pop_front());
               else m_err = 1'b1;
            end
            if (e_hs && e_wen) exp_q.push_back(2'(e_sel));
            if (enable) begin
               if (!m_locked) begin
                  if (e_hs) begin
                     m_last = e_sel;
                     if (BURST_LEN > 1) begin
                        m_locked = 1'b1;
                        m_owner  = e_sel;
                        m_burst  = 1;
                     end
                  end
               end else if (!req[m_owner]) m_locked = 1'b0;
               else if (e_hs) begin
                  m_burst++;
                  if (m_burst == BURST_LEN) m_locked = 1'b0;
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      r_valid = 1'b0;
      if (auto_rsp && resp_due.size() > 0 && resp_due[0] <= cyc) begin
         r_valid = 1'b1;
         void'(resp_due.pop_front());
      end
   endtask

   task automatic drain_and_clear();
      req = 4'b0000; gnt_in = 1'b0; enable = 1'b1; auto_rsp = 1'b1; wen = 4'b0111;
      repeat (16) tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      resp_due.delete();
   endtask

   int rr_seq[4]   = '{0, 1, 2, 0};
   int fair_seq[4] = '{0, 3, 0, 3};
   int n_ol;
   logic [3:0] pend;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #3;
      check("rst_gnt", 32'(gnt_o), 32'h0);
      check("rst_rvalid", 32'(rvalid_o), 32'h0);
      check("rst_tcdm_req", 32'(tcdm_req), 32'h0);
      check("rst_tcdm_wen", 32'(tcdm_wen), 32'h1);
      check("rst_sel", 32'(sel_o), 32'h3);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      tick();

      // Round-robin with full bursts of 8
      req = 4'b0111; gnt_in = 1'b1; resp_lat = 1;
      for (int i = 0; i < 32; i++) begin
         #3;
         check("rr_gnt", 32'(gnt_o), 32'(4'b0001 << rr_seq[i / 8]));
         tick();
      end
      drain_and_clear();

      // Early release: X drops after 3 grants, W takes over after one bubble
      req = 4'b0011; gnt_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #3;
         check("er_x_gnt", 32'(gnt_o), 32'h1);
         tick();
      end
      req = 4'b0010;
      #3;
      check("er_bubble_req", 32'(tcdm_req), 32'h0);
      check("er_bubble_gnt", 32'(gnt_o), 32'h0);
      tick();
      #3;
      check("er_w_gnt", 32'(gnt_o), 32'h2);
      tick();
      drain_and_clear();

      // Outstanding limit with 10-cycle response latency
      resp_lat = 10; req = 4'b0001; gnt_in = 1'b1; n_ol = 0;
      for (int i = 0; i < 10; i++) begin
         #3;
         if (gnt_o[0]) n_ol++;
         tick();
      end
      check("ol_grant_count", 32'(n_ol), 32'd4);
      #3;
      check("ol_blocked_on_pop", 32'(tcdm_req), 32'h0);
      check("ol_first_rvalid", 32'(rvalid_o), 32'h1);
      tick();
      #3;
      check("ol_slot_freed", 32'(tcdm_req), 32'h1);
      tick();
      resp_lat = 1;
      drain_and_clear();

      // Response routing X, W, Y with responses on consecutive cycles
      auto_rsp = 1'b0; r_valid = 1'b0; req = 4'b0001; gnt_in = 1'b1;
      #3; check("rt_x_gnt", 32'(gnt_o), 32'h1); tick();
      req = 4'b0010;
      #3; check("rt_bubble_gnt", 32'(gnt_o), 32'h0); tick();
      #3; check("rt_w_gnt", 32'(gnt_o), 32'h2); tick();
      req = 4'b0100;
      tick();
      #3; check("rt_y_gnt", 32'(gnt_o), 32'h4); tick();
      req = 4'b0000;
      tick();
      for (int i = 0; i < 3; i++) begin
         r_valid = 1'b1;
         #3;
         check("rt_rvalid", 32'(rvalid_o), 32'(4'b0001 << i));
         tick();
      end
      #3;
      check("rt_idle_busy", 32'(busy), 32'h0);
      resp_due.delete();
      drain_and_clear();

      // Store fairness: Z and X alternate bursts, stores are not tracked
      req = 4'b1001; gnt_in = 1'b1; resp_lat = 1;
      for (int i = 0; i < 32; i++) begin
         #3;
         check("fair_gnt", 32'(gnt_o), 32'(4'b0001 << fair_seq[i / 8]));
         check("fair_wen", 32'(tcdm_wen), 32'(fair_seq[i / 8] != 3));
         tick();
      end
      drain_and_clear();

      // Clear with two loads outstanding, then two late responses
      auto_rsp = 1'b0; r_valid = 1'b0; req = 4'b0001; gnt_in = 1'b1;
      tick();
      tick();
      req = 4'b0000;
      tick();
      clear = 1'b1;
      #3; check("cl_busy_before", 32'(busy), 32'h1);
      tick();
      clear = 1'b0;
      #3; check("cl_busy_after", 32'(busy), 32'h0); check("cl_err_after", 32'(err), 32'h0);
      tick();
      r_valid = 1'b1;
      #3; check("cl_late_rvalid0", 32'(rvalid_o), 32'h0);
      tick();
      r_valid = 1'b1;
      #3; check("cl_late_rvalid1", 32'(rvalid_o), 32'h0); check("cl_err_set", 32'(err), 32'h1);
      tick();
      for (int i = 0; i < 3; i++) begin
         #3; check("cl_err_sticky", 32'(err), 32'h1);
         tick();
      end
      clear = 1'b1;
      tick();
      clear = 1'b0;
      #3; check("cl_err_cleared", 32'(err), 32'h0);
      resp_due.delete();
      tick();

      // Randomized traffic: sticky requests, random grant/enable/latency, rare clears and stray responses
      auto_rsp = 1'b1; pend = 4'b0000;
      for (int i = 0; i < 2500; i++) begin
         for (int r = 0; r < 4; r++) begin
            if (exp_gnt_last[r]) pend[r] = ($urandom_range(0, 3) != 0);
            else if (!pend[r]) begin
               pend[r] = ($urandom_range(0, 4) == 0);
               if (r < 3) wen[r] = ($urandom_range(0, 7) != 0);
            end
         end
         req      = pend;
         gnt_in   = ($urandom_range(0, 3) != 0);
         enable   = ($urandom_range(0, 9) != 0);
         clear    = ($urandom_range(0, 299) == 0);
         resp_lat = $urandom_range(1, 8);
         if (!r_valid && $urandom_range(0, 199) == 0) r_valid = 1'b1;
         tick();
      end
      drain_and_clear();
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/redmule_tcdm_scheduler.md
# redmule_tcdm_scheduler

Sequencer for RedMulE's single shared TCDM port. It arbitrates among the X, W and Y load sources and the Z store sink, and drives the channel select of the streamer's load/store multiplexing. It holds a granted requester for a bounded burst and tracks outstanding load responses so each `r_valid` returns to the requester that issued it. Address and data paths stay in the streamer; this block owns only the handshakes and the select.

## Interface
- `NREQ`, 4: requesters; 0=X, 1=W, 2=Y, 3=Z (store).
- `BURST_LEN`, 8: maximum consecutive grants per ownership; ≥1.
- `MAX_OUTSTANDING`, 4: depth of the load-response ID FIFO; power of 2, ≥2.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `clear_i` in 1: synchronous clear, same effect as reset.
- `enable_i` in 1: 0 masks `tcdm_req_o` and freezes all state.
- `req_i` in NREQ: per-requester request.
- `wen_i` in NREQ: per-requester write-enable, 1 = read (HCI polarity); bit 3 is expected 0.
- `gnt_o` out NREQ: per-requester grant (one-hot or zero).
- `rvalid_o` out NREQ: routed response valid (one-hot or zero).
- `sel_o` out $clog2(NREQ): channel select for the streamer mux.
- `tcdm_req_o` out 1: request to TCDM.
- `tcdm_wen_o` out 1: wen of the selected requester.
- `tcdm_gnt_i` in 1: TCDM grant.
- `tcdm_r_valid_i` in 1: TCDM response valid, in order, latency ≥1.
- `busy_o` out 1: state LOCKED, or ID FIFO non-empty.
- `err_o` out 1: sticky; set when a response arrives with the ID FIFO empty.

## Operation
- Handshake (HS) = `tcdm_req_o & tcdm_gnt_i`.
- A load HS is an HS with `tcdm_wen_o=1`. A store HS has `tcdm_wen_o=0`.
- States: IDLE, LOCKED.
- **IDLE**
  - Winner is chosen combinationally by round-robin over `req_i`, starting at `last_owner+1` mod NREQ.
  - `sel_o` = winner. With no request, `sel_o` holds `last_owner`.
  - `tcdm_req_o` = `req_i[winner] & enable_i & ~load_block`.
  - On HS: go to LOCKED, owner = winner, `last_owner` = winner, `burst_cnt` = 1.
- **LOCKED**
  - `sel_o` = owner. `tcdm_req_o` = `req_i[owner] & enable_i & ~load_block`.
  - Each HS increments `burst_cnt`.
  - Exit to IDLE on an HS that makes `burst_cnt == BURST_LEN`.
  - Exit to IDLE in any enabled cycle with `req_i[owner]=0`. That cycle issues no request, so there is one bubble.
  - While owned, other requesters are never granted.
- `load_block` = (`wen_i[sel]=1`) & (`fifo_cnt == MAX_OUTSTANDING`). A pop in the same cycle does not lift the block.
- `gnt_o[sel]` = `tcdm_gnt_i & tcdm_req_o`. All other bits are 0.
- **ID FIFO**
  - Push `sel` on each load HS. Stores are not tracked.
  - Pop on `tcdm_r_valid_i`. `rvalid_o[head]` is asserted combinationally in that cycle.
  - Push and pop in the same cycle leave `fifo_cnt` unchanged.
  - A response with the FIFO empty is dropped, all `rvalid_o` stay 0, and `err_o` is set.
- `burst_cnt` width is $clog2(BURST_LEN+1). It never wraps; the exit fires first.
- Reset or `clear_i` (clear wins over all events in the same cycle):
  - state IDLE, owner 0, `last_owner` = NREQ-1 (requester 0 wins first), `burst_cnt` 0;
  - FIFO flushed, `err_o` 0;
  - in-flight responses arriving after clear count as empty-FIFO responses and set `err_o`.

## Timing
- Reset values: `gnt_o`=0, `rvalid_o`=0, `tcdm_req_o`=0, `tcdm_wen_o`=1, `sel_o`=NREQ-1, `busy_o`=0, `err_o`=0.
- Combinational paths: `req_i`/`wen_i` → `tcdm_req_o`, `sel_o`, `tcdm_wen_o`; `tcdm_gnt_i` → `gnt_o`; `tcdm_r_valid_i` → `rvalid_o`. There are 0 cycles of added request latency.
- State, owner, counters and FIFO update on the rising edge after the event.
- With `enable_i=0` nothing updates. A response arriving while disabled is still routed and popped.
- Requester contract: `req_i` stays high until granted.

## Configuration
- `REDMULE_SCHED_STATS_EN` defined:
  - adds output `grant_cnt_o`, NREQ×32 bits, one counter of HS per requester;
  - adds output `stall_cnt_o`, 32 bits, counting cycles where `req_i[sel]=1` and `tcdm_req_o=0`;
  - counters wrap at 2^32 and are zeroed by reset or `clear_i`.
- Undefined: these ports and their logic are absent.

## Test plan
- **Round-robin:** `req_i`=4'b0111 held, `tcdm_gnt_i`=1, BURST_LEN=8 → grants 0×8, 1×8, 2×8, 0×8. `sel_o` changes only after each 8th grant.
- **Early release:** X requests 3 cycles then drops, W pending → X granted 3 times, one bubble, W granted from the 5th cycle.
- **Outstanding limit:** MAX_OUTSTANDING=4, X loads, `tcdm_gnt_i`=1, responses delayed 10 cycles → exactly 4 grants, then `tcdm_req_o`=0. Each response frees one slot the next cycle.
- **Response routing:** load HS from X, W, Y in order, responses 2 cycles later → `rvalid_o` = 0001, 0010, 0100 on consecutive cycles.
- **Store priority fairness:** Z and X both requesting, BURST_LEN=2 → Z pushes nothing into the FIFO, grants alternate X,X,Z,Z. `tcdm_wen_o`=0 during Z grants.
- **Clear / spurious response:** `clear_i` pulsed with 2 responses outstanding → `busy_o`=0 next cycle. The 2 late `r_valid` give `rvalid_o`=0 and `err_o`=1 until the next clear.
